// File: rtl/cnn_addr_pkg.sv
// cnn_addr_pkg: shared map sizes, output-dimension helper and window FSM states.
package cnn_addr_pkg;

    localparam int IMG_DIM = 28;
    localparam int C1_DIM  = 24;
    localparam int P1_DIM  = 12;
    localparam int C2_DIM  = 8;
    localparam int P2_DIM  = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    function automatic int out_dim(input int in, input int k, input int stride);
        return (in - k) / stride + 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: index counter with a running base that advances by STEP per increment.
// Ports: clk, reset (async, active-high), clear (zero index and base), inc (advance),
//        idx (current index), base (idx*STEP), wrap (idx is at MAX-1).
module wrap_counter #(
    parameter int MAX  = 1,
    parameter int STEP = 1,
    parameter int W    = 8,
    parameter int BW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [W-1:0]  idx,
    output logic [BW-1:0] base,
    output logic          wrap
);

    assign wrap = idx == W'(MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            base <= '0;
        end else if (clear || (inc && wrap)) begin
            idx  <= '0;
            base <= '0;
        end else if (inc) begin
            idx  <= idx + W'(1);
            base <= base + BW'(STEP);
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: sliding-window tap address generator, one K*K window per beat.
// Ports: clk, reset (async, active-high), start (begin a pass when idle),
//        out_ready (consumer accepts beat), busy, out_valid, addr (packed taps,
//        tap i*K+j at [t*ADDR_W +: ADDR_W]), out_row/out_col/out_ch (window indices),
//        first/last (first/final window of the pass), done (pulse after last accept).
module window_addr_gen
    import cnn_addr_pkg::*;
#(
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int K        = 2,
    parameter int STRIDE   = 2,
    parameter int CHANNELS = 1,
    parameter int BASE     = 0,
    parameter int ADDR_W   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic [K*K*ADDR_W-1:0] addr,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col,
    output logic [7:0]            out_ch,
    output logic                  first,
    output logic                  last,
    output logic                  done
);

    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
    localparam int CH_SZ = IMG_W * IMG_H;

    if ((IMG_W - K) % STRIDE != 0) begin : g_chk_w
        $error("window does not tile image width");
    end
    if ((IMG_H - K) % STRIDE != 0) begin : g_chk_h
        $error("window does not tile image height");
    end
    if (longint'(BASE) + longint'(CHANNELS) * CH_SZ > (longint'(1) << ADDR_W)) begin : g_chk_a
        $error("feature maps exceed address space");
    end
    if (OUT_W > 256 || OUT_H > 256 || CHANNELS > 256) begin : g_chk_i
        $error("index outputs limited to 8 bits");
    end

    fsm_e              state, next;
    logic              run, accept, clear;
    logic              col_wrap, row_wrap, ch_wrap;
    logic [ADDR_W-1:0] col_base, row_base, ch_base;

    assign run       = state == RUN;
    assign accept    = run && out_ready;
    assign clear     = state == IDLE && start;
    assign busy      = run;
    assign out_valid = run;
    assign done      = state == DONE;
    assign first     = run && out_col == '0 && out_row == '0 && out_ch == '0;
    assign last      = run && col_wrap && row_wrap && ch_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        if (clear)          next = RUN;
        if (accept && last) next = DONE;
        if (state == DONE)  next = IDLE;
    end

    // Column wraps carry into row, row wraps carry into channel.
    wrap_counter #(.MAX(OUT_W), .STEP(STRIDE), .W(8), .BW(ADDR_W)) u_col (
        .clk(clk), .reset(reset), .clear(clear), .inc(accept),
        .idx(out_col), .base(col_base), .wrap(col_wrap)
    );

    wrap_counter #(.MAX(OUT_H), .STEP(STRIDE * IMG_W), .W(8), .BW(ADDR_W)) u_row (
        .clk(clk), .reset(reset), .clear(clear), .inc(accept && col_wrap),
        .idx(out_row), .base(row_base), .wrap(row_wrap)
    );

    wrap_counter #(.MAX(CHANNELS), .STEP(CH_SZ), .W(8), .BW(ADDR_W)) u_ch (
        .clk(clk), .reset(reset), .clear(clear), .inc(accept && col_wrap && row_wrap),
        .idx(out_ch), .base(ch_base), .wrap(ch_wrap)
    );

    // Each tap is the window base plus a constant row/column offset; bus reads zero when idle.
    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign addr[(i*K+j)*ADDR_W +: ADDR_W] =
                run ? ADDR_W'(BASE + i*IMG_W + j) + ch_base + row_base + col_base : '0;
        end
    end

endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: three configurations driven together and checked against an index-based window model.
module tb_window_addr_gen;

    logic clk = 0, reset = 1, start = 0, out_ready = 0;
    logic       valid[3], busy[3], first[3], last[3], done[3];
    logic [7:0] orow[3], ocol[3], och[3];
    logic [39:0]  addr0;
    logic [43:0]  addr1;
    logic [249:0] addr2;

    int checks = 0, failures = 0;
    int n[3], mode[3];
    int ow[3]  = '{12, 12, 24};
    int oh[3]  = '{12, 12, 24};
    int tot[3] = '{144, 288, 576};
    int iw[3]  = '{24, 24, 28};
    int kk[3]  = '{2, 2, 5};
    int st[3]  = '{2, 2, 1};
    int csz[3] = '{576, 576, 784};

    always #5 clk = ~clk;

    window_addr_gen d0 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .busy(busy[0]), .out_valid(valid[0]), .addr(addr0),
        .out_row(orow[0]), .out_col(ocol[0]), .out_ch(och[0]),
        .first(first[0]), .last(last[0]), .done(done[0])
    );

    window_addr_gen #(.CHANNELS(2), .ADDR_W(11)) d1 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .busy(busy[1]), .out_valid(valid[1]), .addr(addr1),
        .out_row(orow[1]), .out_col(ocol[1]), .out_ch(och[1]),
        .first(first[1]), .last(last[1]), .done(done[1])
    );

    window_addr_gen #(.IMG_W(28), .IMG_H(28), .K(5), .STRIDE(1)) d2 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .busy(busy[2]), .out_valid(valid[2]), .addr(addr2),
        .out_row(orow[2]), .out_col(ocol[2]), .out_ch(och[2]),
        .first(first[2]), .last(last[2]), .done(done[2])
    );

    function automatic logic [31:0] get_tap(input int d, input int t);
        if (d == 0) return 32'(addr0[t*10 +: 10]);
        if (d == 1) return 32'(addr1[t*11 +: 11]);
        return 32'(addr2[t*10 +: 10]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int d);
        int c, r, ch;
        c  = n[d] % ow[d];
        r  = (n[d] / ow[d]) % oh[d];
        ch = n[d] / (ow[d] * oh[d]);
        if (mode[d] == 1) begin
            chk($sformatf("d%0d_n%0d_valid", d, n[d]), 32'(valid[d]), 1);
            chk($sformatf("d%0d_n%0d_busy", d, n[d]), 32'(busy[d]), 1);
            chk($sformatf("d%0d_n%0d_done", d, n[d]), 32'(done[d]), 0);
            chk($sformatf("d%0d_n%0d_col", d, n[d]), 32'(ocol[d]), c);
            chk($sformatf("d%0d_n%0d_row", d, n[d]), 32'(orow[d]), r);
            chk($sformatf("d%0d_n%0d_ch", d, n[d]), 32'(och[d]), ch);
            chk($sformatf("d%0d_n%0d_first", d, n[d]), 32'(first[d]), 32'(n[d] == 0));
            chk($sformatf("d%0d_n%0d_last", d, n[d]), 32'(last[d]), 32'(n[d] == tot[d] - 1));
            for (int i = 0; i < kk[d]; i++)
                for (int j = 0; j < kk[d]; j++)
                    chk($sformatf("d%0d_n%0d_tap%0d", d, n[d], i*kk[d]+j), get_tap(d, i*kk[d]+j),
                        ch*csz[d] + (r*st[d] + i)*iw[d] + c*st[d] + j);
        end else begin
            chk($sformatf("d%0d_idle_valid", d), 32'(valid[d]), 0);
            chk($sformatf("d%0d_idle_busy", d), 32'(busy[d]), 0);
            chk($sformatf("d%0d_done", d), 32'(done[d]), 32'(mode[d] == 2));
        end
    endtask

    task automatic chk_zero(input int d);
        chk($sformatf("d%0d_rst_valid", d), 32'(valid[d]), 0);
        chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 0);
        chk($sformatf("d%0d_rst_done", d), 32'(done[d]), 0);
        chk($sformatf("d%0d_rst_first", d), 32'(first[d]), 0);
        chk($sformatf("d%0d_rst_last", d), 32'(last[d]), 0);
        chk($sformatf("d%0d_rst_row", d), 32'(orow[d]), 0);
        chk($sformatf("d%0d_rst_col", d), 32'(ocol[d]), 0);
        chk($sformatf("d%0d_rst_ch", d), 32'(och[d]), 0);
        for (int t = 0; t < kk[d]*kk[d]; t++)
            chk($sformatf("d%0d_rst_tap%0d", d, t), get_tap(d, t), 0);
    endtask

    // rnd: random out_ready; b2b: restarts of d0 on the cycle after its done; rst_at: d0 beat to reset on.
    task automatic run_pass(input bit rnd, input int b2b, input int rst_at);
        int  cyc;
        bit  prev_done0, all_run, all_idle, restart;
        cyc = 0;
        prev_done0 = 0;
        while (1) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_inst(d);
            all_idle = mode[0] == 0 && mode[1] == 0 && mode[2] == 0;
            all_run  = mode[0] == 1 && mode[1] == 1 && mode[2] == 1;
            restart  = b2b > 0 && prev_done0 && mode[0] == 0;
            if (cyc > 0 && all_idle && !restart) begin
                start = 0;
                return;
            end
            if (cyc >= 20000) begin
                chk("timeout", 1, 0);
                start = 0;
                return;
            end
            if (rst_at >= 0 && mode[0] == 1 && n[0] == rst_at) begin
                start = 0;
                reset = 1;
                #1;
                for (int d = 0; d < 3; d++) chk_zero(d);
                @(negedge clk);
                for (int d = 0; d < 3; d++) chk_zero(d);
                reset = 0;
                for (int d = 0; d < 3; d++) begin
                    mode[d] = 0;
                    n[d] = 0;
                end
                return;
            end
            if (restart) b2b--;
            start = cyc == 0 || restart || (all_run && $urandom_range(9) == 0);
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            prev_done0 = mode[0] == 2;
            for (int d = 0; d < 3; d++) begin
                if (mode[d] == 2) mode[d] = 0;
                else if (mode[d] == 1 && out_ready) begin
                    n[d]++;
                    if (n[d] == tot[d]) mode[d] = 2;
                end else if (mode[d] == 0 && start) begin
                    mode[d] = 1;
                    n[d] = 0;
                end
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            n[d] = 0;
            mode[d] = 0;
        end
        reset = 1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_zero(d);
        reset = 0;
        run_pass(0, 0, -1);
        run_pass(1, 0, -1);
        run_pass(0, 0, 70);
        out_ready = 1;
        run_pass(0, 1, -1);
        run_pass(1, 1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
